vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Scan-side counterpart of the pixel colouriser. Generates 640x480@60 VGA timing from the 100 MHz clk.
//  - Drives pixel coordinates x/y to the colouriser.
//  - Takes back its registered r/g/b and outputs blank-gated colour plus hsync/vsync, all aligned.
//  - Provides frame_start, a one-clk pulse per frame, usable as the game-move tick.
// PARAMETERS
//  CLK_DIV   4    clk cycles per pixel (>=1); 4 -> 25 MHz pixel rate
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync width, pixels
//  H_BP      48   horizontal back porch, pixels
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync width, lines
//  V_BP      33   vertical back porch, lines
//  SYNC_POL  0    sync active level (0 = active-low)
// PORTS
//  clk          in   1   system clock, 100 MHz; single clock domain
//  rst_n        in   1   asynchronous, active-low reset
//  pix_tick     out  1   one-clk pixel enable, every CLK_DIV clks
//  x            out  10  horizontal counter 0..H_TOTAL-1, to colouriser
//  y            out  10  vertical counter 0..V_TOTAL-1, to colouriser
//  frame_start  out  1   one-clk pulse when counters wrap to (0,0)
//  r_in/g_in/b_in in 4   colour from colouriser, valid 1 clk after x/y
//  vga_r/g/b    out  4   gated colour to DAC pins
//  hsync        out  1   horizontal sync, level per SYNC_POL
//  vsync        out  1   vertical sync, level per SYNC_POL
// BEHAVIOUR
//  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
//  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//  - Tick counter: counts 0..CLK_DIV-1. pix_tick=1 for the clk in which tick counter==CLK_DIV-1.
//    With CLK_DIV=1, pix_tick is constantly 1.
//  - h_cnt advances only on pix_tick. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
//  - v_cnt wraps V_TOTAL-1 -> 0 on the same edge that h_cnt wraps.
//  - x=h_cnt, y=v_cnt, registered. No blanking gating on x/y.
//  - Derived from counters (combinational, stage 0):
//    - act = h<H_ACTIVE && v<V_ACTIVE
//    - hs  = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751)
//    - vs  = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491)
//  - Stage 1: act/hs/vs registered every clk, to match the colouriser's 1-clk register.
//  - Stage 2, every clk:
//    - vga_* <= act_d1 ? {r,g,b}_in : 0
//    - hsync <= hs_d1 ? SYNC_POL : ~SYNC_POL (vsync likewise)
//  - Outputs therefore lag x/y by exactly 2 clks, mutually aligned.
//  - frame_start: registered. High for the one clk after the edge where (h,v) goes (799,524)->(0,0).
//  - Counters are 10 bits; no overflow is possible for the defaults. Widths are fixed, not parameter-scaled.
//  - Reset (asynchronous, immediate, including mid-frame), all outputs and state:
//    - tick, h, v = 0; delay regs cleared
//    - pix_tick=0, frame_start=0, vga_*=0
//    - hsync/vsync = ~SYNC_POL (inactive)
//  - After rst_n rises:
//    - first pix_tick in the CLK_DIV-th clk
//    - first h advance on that tick
//    - no frame_start until the first full wrap
//  - rgb_in is ignored whenever act_d1=0 (porches and sync).
// STRUCTURE
//  - Package vga_pkg: default H/V timing constants, H_TOTAL/V_TOTAL, SYNC_POL default.
//  - One sub-module, vga_pix_tick: CLK_DIV clock-enable counter producing pix_tick. No generated clocks.
//  - Counters, sync decode and the 2-stage align pipeline stay in the top.
// TESTING (defaults unless noted; colouriser modelled as 1-clk register)
//  1. Reset release -> pix_tick first high in clk 4; x=y=0; vga_*=0; hsync=vsync=1.
//  2. Run 1 line -> x steps 0..799 then 0; line period 3200 clks; hsync low for exactly 384 clks
//     (96 px), starting 2 clks after x becomes 656.
//  3. Run 2 frames -> vsync low for exactly 2 lines (y 490..491).
//     frame_start pulses exactly once per 1,680,000 clks, each pulse 1 clk wide.
//  4. rgb_in held F/F/F -> vga_* = F for exactly 307,200 pixel ticks per frame.
//     vga_* = 0 whenever delayed x>=640 or y>=480.
//  5. rst_n low at x=300,y=200 -> same clk: vga_*=0, syncs inactive, x=y=0.
//     Timing restarts from (0,0) on release.
//  6. CLK_DIV=1 -> pix_tick constant 1; line = 800 clks; frame_start period 420,000 clks.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60 from a 100 MHz clock) and a small
// window-decode helper used by the timing generator.
package vga_pkg;

  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam bit VGA_SYNC_POL = 1'b0;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // True when a counter value lies in the inclusive window [lo, hi].
  function automatic logic in_window(input logic [9:0] c,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel clock-enable: a one-clk pulse every CLK_DIV system clocks.
// No derived clock is generated; everything downstream stays on clk.
module vga_pix_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider counter, 0..CLK_DIV-1, restarting at 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Gated with rst_n so the enable is quiet during reset even when CLK_DIV=1.
  assign pix_tick = rst_n && (cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel/line counters, sync/blank decode and a
// two-stage alignment pipeline matching the colouriser's one-clk register.
module vga_timing_gen import vga_pkg::*; #(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = VGA_SYNC_POL
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       hsync,
  output logic       vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       act;
  logic       hs;
  logic       vs;
  logic       act_d1;
  logic       hs_d1;
  logic       vs_d1;

  vga_pix_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .pix_tick(pix_tick)
  );

  assign x = h_cnt;
  assign y = v_cnt;

  // Raster counters: h steps on each pixel tick, v steps when h wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + 10'd1;
        end
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // One-clk pulse following the edge that wraps the raster back to (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end
  end

  // Stage 0: visible-area and sync windows decoded straight from the counters.
  always_comb begin
    act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs  = in_window(h_cnt, HS_FIRST, HS_LAST);
    vs  = in_window(v_cnt, VS_FIRST, VS_LAST);
  end

  // Stage 1: delay the decode one clk so it lines up with the colouriser output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_d1 <= 1'b0;
      hs_d1  <= 1'b0;
      vs_d1  <= 1'b0;
    end else begin
      act_d1 <= act;
      hs_d1  <= hs;
      vs_d1  <= vs;
    end
  end

  // Stage 2: blank-gate the colour and drive the sync pins at their active level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r <= 4'd0;
      vga_g <= 4'd0;
      vga_b <= 4'd0;
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
    end else begin
      vga_r <= act_d1 ? r_in : 4'd0;
      vga_g <= act_d1 ? g_in : 4'd0;
      vga_b <= act_d1 ? b_in : 4'd0;
      hsync <= hs_d1 ? SYNC_POL : ~SYNC_POL;
      vsync <= vs_d1 ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster so whole frames fit in a
// short run. Two instances: CLK_DIV=4 active-low syncs, CLK_DIV=1 active-high.
module tb_vga_timing_gen;

  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int DA = 4;
  localparam int DB = 1;
  localparam bit POLA = 1'b0;
  localparam bit POLB = 1'b1;

  typedef struct {
    int cycles;
    int ex;
    int ey;
    bit ept;
    bit efs;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       ptA, fsA, hsA, vsA;
  logic [9:0] xA, yA;
  logic [3:0] rA, gA, bA, vrA, vgA, vbA;
  logic       ptB, fsB, hsB, vsB;
  logic [9:0] xB, yB;
  logic [3:0] rB, gB, bB, vrB, vgB, vbB;

  int checks = 0;
  int failures = 0;
  int k = 0;
  bit inReset = 1'b1;
  bit holdWhite = 1'b0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(DA), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POLA)
  ) dutA (
    .clk(clk), .rst_n(rst_n), .pix_tick(ptA), .x(xA), .y(yA),
    .frame_start(fsA), .r_in(rA), .g_in(gA), .b_in(bA),
    .vga_r(vrA), .vga_g(vgA), .vga_b(vbA), .hsync(hsA), .vsync(vsA)
  );

  vga_timing_gen #(
    .CLK_DIV(DB), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(POLB)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .pix_tick(ptB), .x(xB), .y(yB),
    .frame_start(fsB), .r_in(rB), .g_in(gB), .b_in(bB),
    .vga_r(vrB), .vga_g(vgB), .vga_b(vbB), .hsync(hsB), .vsync(vsB)
  );

  // Reference: everything follows from k, the number of clk edges since release.
  // Pixels elapsed = k/d; outputs reflect the raster position two clks earlier
  // and the colour presented during the previous clk.
  function automatic logic [35:0] model(input int kk, input int d, input bit pol,
                                        input bit rst, input logic [11:0] rgbPrev);
    int p, h, v, p2, h2, v2;
    logic pt, fs, hsy, vsy;
    logic [11:0] col;
    if (rst) return {1'b0, 10'd0, 10'd0, 1'b0, 12'd0, ~pol, ~pol};
    p = kk / d;
    h = p % HT;
    v = (p / HT) % VT;
    pt = ((kk % d) == d - 1);
    fs = (kk > 0) && ((kk % d) == 0) && ((p % (HT * VT)) == 0);
    col = 12'd0;
    hsy = ~pol;
    vsy = ~pol;
    if (kk >= 2) begin
      p2 = (kk - 2) / d;
      h2 = p2 % HT;
      v2 = (p2 / HT) % VT;
      if (h2 < HA && v2 < VA) col = rgbPrev;
      if (h2 >= HA + HF && h2 < HA + HF + HS) hsy = pol;
      if (v2 >= VA + VF && v2 < VA + VF + VS) vsy = pol;
    end
    return {pt, 10'(h), 10'(v), fs, col, hsy, vsy};
  endfunction

  task automatic checkOutput(input string tag);
    logic [35:0] actA, expA, actB, expB;
    actA = {ptA, xA, yA, fsA, vrA, vgA, vbA, hsA, vsA};
    expA = model(k, DA, POLA, inReset, {rA, gA, bA});
    actB = {ptB, xB, yB, fsB, vrB, vgB, vbB, hsB, vsB};
    expB = model(k, DB, POLB, inReset, {rB, gB, bB});
    checks++;
    if (actA !== expA) begin
      failures++;
      $display("[TB] FAIL %s instA k=%0d actual=%h required=%h", tag, k, actA, expA);
    end
    checks++;
    if (actB !== expB) begin
      failures++;
      $display("[TB] FAIL %s instB k=%0d actual=%h required=%h", tag, k, actB, expB);
    end
  endtask

  task automatic applyStimulus();
    if (holdWhite) begin
      {rA, gA, bA} = 12'hFFF;
      {rB, gB, bB} = 12'hFFF;
    end else begin
      {rA, gA, bA} = 12'($urandom);
      {rB, gB, bB} = 12'($urandom);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    if (!inReset) k++;
    @(negedge clk);
    checkOutput("cycle");
    applyStimulus();
  endtask

  // Assert reset mid low-phase, check it acts at once, release on a negedge.
  task automatic doReset();
    #2;
    rst_n = 1'b0;
    inReset = 1'b1;
    #1;
    checkOutput("async_reset");
    @(negedge clk);
    checkOutput("reset_hold");
    rst_n = 1'b1;
    inReset = 1'b0;
    k = 0;
    #1;
    checkOutput("release");
    applyStimulus();
  endtask

  task automatic checkCount(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", tag, got, want);
    end
  endtask

  initial begin
    vec_t tbl[8];
    int hsLowA, vsLowA, fsCntA, whiteA, hsHighB, fsCntB;
    bit found;

    tbl[0] = '{0,   0,  0, 1'b0, 1'b0};
    tbl[1] = '{3,   0,  0, 1'b1, 1'b0};
    tbl[2] = '{4,   1,  0, 1'b0, 1'b0};
    tbl[3] = '{59,  14, 0, 1'b1, 1'b0};
    tbl[4] = '{60,  0,  1, 1'b0, 1'b0};
    tbl[5] = '{599, 14, 9, 1'b1, 1'b0};
    tbl[6] = '{600, 0,  0, 1'b0, 1'b1};
    tbl[7] = '{601, 0,  0, 1'b0, 1'b0};

    applyStimulus();
    @(negedge clk);
    checkOutput("power_on_reset");

    // Hand-computed raster positions on the CLK_DIV=4 instance.
    for (int i = 0; i < 8; i++) begin
      doReset();
      repeat (tbl[i].cycles) stepCycle();
      checks++;
      if (xA !== 10'(tbl[i].ex) || yA !== 10'(tbl[i].ey) ||
          ptA !== tbl[i].ept || fsA !== tbl[i].efs) begin
        failures++;
        $display("[TB] FAIL table[%0d] actual x=%0d y=%0d pt=%b fs=%b required x=%0d y=%0d pt=%b fs=%b",
                 i, xA, yA, ptA, fsA, tbl[i].ex, tbl[i].ey, tbl[i].ept, tbl[i].efs);
      end
    end

    // Two frames of white input: sync widths, frame pulses and visible area.
    doReset();
    holdWhite = 1'b1;
    applyStimulus();
    hsLowA = 0; vsLowA = 0; fsCntA = 0; whiteA = 0; hsHighB = 0; fsCntB = 0;
    for (int c = 0; c < 1200; c++) begin
      stepCycle();
      if (hsA == 1'b0) hsLowA++;
      if (vsA == 1'b0) vsLowA++;
      if (fsA) fsCntA++;
      if (vrA == 4'hF && vgA == 4'hF && vbA == 4'hF) whiteA++;
      if (hsB == 1'b1) hsHighB++;
      if (fsB) fsCntB++;
    end
    holdWhite = 1'b0;
    checkCount("hsync_low_clks_A", hsLowA, 240);
    checkCount("vsync_low_clks_A", vsLowA, 240);
    checkCount("frame_start_A", fsCntA, 2);
    checkCount("white_clks_A", whiteA, 384);
    checkCount("hsync_high_clks_B", hsHighB, 240);
    checkCount("frame_start_B", fsCntB, 8);

    // Reset in the middle of the visible area must clear everything at once.
    doReset();
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      stepCycle();
      if (xA == 10'd5 && yA == 10'd3) found = 1'b1;
    end
    checkCount("reached_mid_frame", int'(found), 1);
    doReset();
    repeat (100) stepCycle();

    // Random colour with occasional random resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) doReset();
      stepCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
